jk_bank_ctrl: RTL and testbench

- Command sequencer that owns a bank of WIDTH J-K flip-flop cells and drives their J/K inputs to perform clear, set, load, toggle and multi-step up/down counting.
- Commands arrive over a valid/ready handshake. Completion is signalled by a one-cycle done pulse.
- Sits between a host/control FSM and the flip-flop storage, so no other block drives J/K directly.

---
 rtl/jk_pkg.sv | 30 +++
 rtl/jk_cell.sv | 32 +++
 rtl/jk_bank_ctrl.sv | 135 +++++++++++++
 tb/tb_jk_bank_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared opcodes, FSM encoding and J/K pair constants for the J-K bank controller
// Contents: OP_* opcodes (3 bits), ST_* FSM states (2 bits), JK_* {j,k} pair codes,
//           is_count_op() helper.
package jk_pkg;

    localparam logic [2:0] OP_HOLD   = 3'd0;
    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_LOAD   = 3'd3;
    localparam logic [2:0] OP_TOGGLE = 3'd4;
    localparam logic [2:0] OP_CNT_UP = 3'd5;
    localparam logic [2:0] OP_CNT_DN = 3'd6;
    localparam logic [2:0] OP_RSVD   = 3'd7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_COUNT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Encoded as {j, k}
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    function automatic logic is_count_op(input logic [2:0] op);
        return (op == OP_CNT_UP) || (op == OP_CNT_DN);
    endfunction

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single J-K flip-flop cell
// Ports: clk (rising edge), clr_n (sync active-low clear), j, k (inputs), q, q_n (outputs).
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic clr_n,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_n
);

    logic q_q;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            q_q <= 1'b0;
        end else begin
            case ({j, k})
                JK_HOLD:  q_q <= q_q;
                JK_RESET: q_q <= 1'b0;
                JK_SET:   q_q <= 1'b1;
                default:  q_q <= ~q_q;
            endcase
        end
    end

    assign q   = q_q;
    assign q_n = ~q_q;

endmodule

// File: rtl/jk_bank_ctrl.sv
// rtl/jk_bank_ctrl.sv - command sequencer driving J/K inputs of a WIDTH-bit J-K flip-flop bank
// Ports: clk, clr_n (sync active-low); cmd_valid/cmd_ready handshake with cmd_op, cmd_data,
//        cmd_len; q (bank state); busy, done (1-cycle completion pulse), wrap (1-cycle count wrap).
module jk_bank_ctrl
    import jk_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_len,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    logic [1:0]       state_q, state_d;
    logic [2:0]       op_q,    op_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             wrap_q,  wrap_d;

    logic [WIDTH-1:0] q_n;
    logic [WIDTH-1:0] up_en;
    logic [WIDTH-1:0] dn_en;
    logic [WIDTH-1:0] j_w;
    logic [WIDTH-1:0] k_w;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    data_d = cmd_data;
                    if (is_count_op(cmd_op)) begin
                        cnt_d   = cmd_len;
                        state_d = (cmd_len == '0) ? ST_DONE : ST_COUNT;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: state_d = ST_DONE;
            ST_COUNT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // The step taken this cycle wraps if every bit carries (up) or borrows (down);
                // registering it lines the pulse up with q showing the wrapped value.
                wrap_d = (op_q == OP_CNT_UP) ? (&q) : (&q_n);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_HOLD;
            data_q  <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        j_w = '0;
        k_w = '0;
        if (state_q == ST_EXEC) begin
            case (op_q)
                OP_CLEAR:  k_w = '1;
                OP_SET:    j_w = '1;
                OP_LOAD: begin
                    j_w = data_q;
                    k_w = ~data_q;
                end
                OP_TOGGLE: begin
                    j_w = data_q;
                    k_w = data_q;
                end
                default: begin
                    j_w = '0;
                    k_w = '0;
                end
            endcase
        end else if (state_q == ST_COUNT) begin
            j_w = (op_q == OP_CNT_UP) ? up_en : dn_en;
            k_w = j_w;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        // Bit g toggles when all lower bits are 1 (up) or all are 0 (down).
        if (g == 0) begin : g_lsb
            assign up_en[g] = 1'b1;
            assign dn_en[g] = 1'b1;
        end else begin : g_upper
            assign up_en[g] = &q[g-1:0];
            assign dn_en[g] = &q_n[g-1:0];
        end

        jk_cell u_cell (
            .clk   (clk),
            .clr_n (clr_n),
            .j     (j_w[g]),
            .k     (k_w[g]),
            .q     (q[g]),
            .q_n   (q_n[g])
        );
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// tb/tb_jk_bank_ctrl.sv - scoreboard testbench for jk_bank_ctrl
module tb_jk_bank_ctrl;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] cmd_len;
    logic [7:0] q;
    logic       busy;
    logic       done;
    logic       wrap;

    jk_bank_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [7:0] qv;
        int         c;
    } exp_t;

    exp_t done_sb[$];
    exp_t wrap_sb[$];
    int   busy_sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboards whenever the DUT presents done, wrap or the end of a busy run.
    int   run = 0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (clr_n !== 1'b1) begin
            run = 0;
        end else begin
            if (done === 1'b1) begin
                if (done_sb.size() == 0) begin
                    chk("unexpected_done", done, 0);
                end else begin
                    mon_e = done_sb.pop_front();
                    chk("done_q", q, mon_e.qv);
                    chk("done_cycle", cyc, mon_e.c);
                end
            end
            if (wrap === 1'b1) begin
                if (wrap_sb.size() == 0) begin
                    chk("unexpected_wrap", wrap, 0);
                end else begin
                    mon_e = wrap_sb.pop_front();
                    chk("wrap_q", q, mon_e.qv);
                    chk("wrap_cycle", cyc, mon_e.c);
                end
            end
            if (busy === 1'b1) begin
                run++;
            end else if (run > 0) begin
                if (busy_sb.size() == 0) chk("unexpected_busy", run, 0);
                else chk("busy_len", run, busy_sb.pop_front());
                run = 0;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [7:0] data, input logic [7:0] len,
                         input logic [7:0] exp_q, input bit abort, output int acc);
        int guard;
        int lat;
        cmd_op    = op;
        cmd_data  = data;
        cmd_len   = len;
        cmd_valid = 1'b1;
        guard     = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) chk("ready_timeout", cmd_ready, 1);
        @(posedge clk);
        #1;
        acc       = cyc;
        cmd_valid = 1'b0;
        if (op == 3'd5 || op == 3'd6) lat = (len == 0) ? 1 : int'(len) + 1;
        else lat = 2;
        if (!abort) begin
            done_sb.push_back('{qv: exp_q, c: acc + lat - 1});
            busy_sb.push_back(lat);
        end
    endtask

    task automatic trace(input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3, input int n);
        logic [7:0] ev [4];
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("count_step", q, ev[i]);
        end
    endtask

    int a0, a1, a2, a3;

    initial begin
        clr_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 3'd2;
        cmd_data  = 8'h00;
        cmd_len   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", q, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wrap", wrap, 0);
        clr_n = 1'b1;
        chk("rst_ready", cmd_ready, 1);
        issue(3'd2, 8'h00, 8'd0, 8'hFF, 0, a0);

        issue(3'd3, 8'hA5, 8'd0, 8'hA5, 0, a0);
        issue(3'd4, 8'h0F, 8'd0, 8'hAA, 0, a1);
        chk("gap_load_toggle", a1 - a0, 3);
        issue(3'd0, 8'hFF, 8'd0, 8'hAA, 0, a2);
        issue(3'd7, 8'h55, 8'd0, 8'hAA, 0, a3);
        chk("gap_hold_rsvd", a3 - a2, 3);

        issue(3'd2, 8'h00, 8'd0, 8'hFF, 0, a0);
        issue(3'd1, 8'h00, 8'd0, 8'h00, 0, a1);
        chk("gap_set_clear", a1 - a0, 3);

        issue(3'd3, 8'hFD, 8'd0, 8'hFD, 0, a0);
        issue(3'd5, 8'h00, 8'd4, 8'h01, 0, a1);
        wrap_sb.push_back('{qv: 8'h00, c: a1 + 3});
        trace(8'hFE, 8'hFF, 8'h00, 8'h01, 4);

        issue(3'd3, 8'h01, 8'd0, 8'h01, 0, a0);
        issue(3'd6, 8'h00, 8'd3, 8'hFE, 0, a1);
        wrap_sb.push_back('{qv: 8'hFF, c: a1 + 2});
        trace(8'h00, 8'hFF, 8'hFE, 8'h00, 3);
        issue(3'd6, 8'h00, 8'd0, 8'hFE, 0, a2);

        issue(3'd3, 8'h00, 8'd0, 8'h00, 0, a0);
        issue(3'd5, 8'h00, 8'd200, 8'h00, 1, a1);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_pre_q", q, 8'h0A);
        clr_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_q", q, 8'h00);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_wrap", wrap, 0);
        clr_n = 1'b1;
        chk("abort_ready", cmd_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        issue(3'd3, 8'h3C, 8'd0, 8'h3C, 0, a0);

        for (int i = 0; i < 50 && (done_sb.size() + wrap_sb.size() + busy_sb.size()) != 0; i++)
            @(negedge clk);
        repeat (3) @(negedge clk);
        chk("done_sb_empty", done_sb.size(), 0);
        chk("wrap_sb_empty", wrap_sb.size(), 0);
        chk("busy_sb_empty", busy_sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
